// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter / branch unit.
package pc_pkg;

    localparam int PC_W_DEF      = 8;
    localparam int RAS_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        BLT  = 3'd0,
        BNE  = 3'd1,
        BEQ  = 3'd2,
        BGE  = 3'd3,
        JMP  = 3'd4,
        CALL = 3'd5,
        RET  = 3'd6,
        RSV  = 3'd7
    } br_mode_t;

    // Conditional-branch decision from the signed comparison result (a-b).
    function automatic logic cond_taken(br_mode_t mode, logic [7:0] cmp);
        case (mode)
            BLT:     return cmp[7];
            BNE:     return cmp != 8'd0;
            BEQ:     return cmp == 8'd0;
            BGE:     return !cmp[7];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pc_branch_unit_if.sv
// Control-transfer request inputs and PC / return-stack status outputs.
interface pc_branch_if
    import pc_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF
);
    logic                             halt;
    logic                             br_en;
    br_mode_t                         br_mode;
    logic [7:0]                       cmp;
    logic [PC_W-1:0]                  offset;
    logic [PC_W-1:0]                  pc;
    logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count;
    logic                             ras_overflow;
    logic                             ras_underflow;

    modport master (
        output halt, br_en, br_mode, cmp, offset,
        input  pc, ras_count, ras_overflow, ras_underflow
    );

    modport slave (
        input  halt, br_en, br_mode, cmp, offset,
        output pc, ras_count, ras_overflow, ras_underflow
    );
endinterface

// File: rtl/ras_stack.sv
// Return-address stack: LIFO of link addresses with occupancy count.
module ras_stack #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           hold,
    input  logic                           push,
    input  logic                           pop,
    input  logic [W-1:0]                   push_data,
    output logic                           full,
    output logic                           empty,
    output logic [W-1:0]                   top,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [0:(1<<IW)-1];
    logic [CW-1:0] count_q = '0;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] top_idx;

    assign wr_idx  = IW'(count_q);
    assign top_idx = wr_idx - IW'(1);
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign top     = mem[top_idx];
    assign count   = count_q;

    // Occupancy count: push grows, pop shrinks, hold freezes.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            count_q <= '0;
        end else if (!hold) begin
            if (push && !full)
                count_q <= count_q + CW'(1);
            else if (pop && !empty)
                count_q <= count_q - CW'(1);
        end
    end

    // Entry storage: written on a legal push only.
    always_ff @(posedge clk) begin
        // NOTE: entries have no reset; a zero count already makes stale contents unreachable.
        if (!reset && !hold && push && !full)
            mem[wr_idx] <= push_data;
    end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter with conditional branches, jumps and call/return via a return-address stack.
module pc_branch_unit
    import pc_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        reset,
    pc_branch_if.slave  bus
);
    logic [PC_W-1:0] pc_q = '0;
    logic            ovf_q = 1'b0;
    logic            unf_q = 1'b0;

    logic [PC_W-1:0] pc_seq;
    logic [PC_W-1:0] pc_rel;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] ras_top;
    logic            ras_full;
    logic            ras_empty;
    logic            do_push;
    logic            do_pop;
    logic            set_ovf;
    logic            set_unf;

    // Next-PC selection and stack requests for the current instruction.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        pc_seq  = pc_q + PC_W'(1);
        pc_rel  = pc_q + bus.offset;
        pc_next = pc_seq;
        do_push = 1'b0;
        do_pop  = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (bus.br_en) begin
            case (bus.br_mode)
                BLT, BNE, BEQ, BGE: begin
                    if (cond_taken(bus.br_mode, bus.cmp))
                        pc_next = pc_rel;
                end
                JMP: pc_next = pc_rel;
                CALL: begin
                    pc_next = pc_rel;
                    if (ras_full) set_ovf = 1'b1;
                    else          do_push = 1'b1;
                end
                RET: begin
                    if (ras_empty) begin
                        set_unf = 1'b1;
                    end else begin
                        pc_next = ras_top;
                        do_pop  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // PC and sticky stack-error flags; reset beats halt.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (!bus.halt) begin
            pc_q <= pc_next;
            if (set_ovf) ovf_q <= 1'b1;
            if (set_unf) unf_q <= 1'b1;
        end
    end

    ras_stack #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .hold      (bus.halt),
        .push      (do_push),
        .pop       (do_pop),
        .push_data (pc_seq),
        .full      (ras_full),
        .empty     (ras_empty),
        .top       (ras_top),
        .count     (bus.ras_count)
    );

    assign bus.pc            = pc_q;
    assign bus.ras_overflow  = ovf_q;
    assign bus.ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboard bench: driver pushes reference-model expectations, monitor pops and compares after each edge.
module tb_pc_branch_unit;
    import pc_pkg::*;

    localparam int PC_W      = 8;
    localparam int RAS_DEPTH = 4;
    localparam int MASK      = (1 << PC_W) - 1;

    typedef struct {
        int    pc;
        int    cnt;
        int    ovf;
        int    unf;
        string tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   tests  = 0;
    int   failed = 0;
    exp_t sb[$];

    // reference model state
    int m_pc = 0;
    int m_stack[$];
    int m_ovf = 0;
    int m_unf = 0;

    pc_branch_if #(.PC_W(PC_W), .RAS_DEPTH(RAS_DEPTH)) bus ();

    pc_branch_unit #(.PC_W(PC_W), .RAS_DEPTH(RAS_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(string name, int act, int exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply one instruction at the falling edge and queue the model's post-edge state.
    task automatic drive(bit rst, bit hlt, bit en, br_mode_t mode, logic [7:0] c,
                         logic [7:0] off, string tag);
        exp_t e;
        @(negedge clk);
        reset       = rst;
        bus.halt    = hlt;
        bus.br_en   = en;
        bus.br_mode = mode;
        bus.cmp     = c;
        bus.offset  = off;
        if (rst) begin
            m_pc = 0;
            m_stack.delete();
            m_ovf = 0;
            m_unf = 0;
        end else if (!hlt) begin
            int sc;
            sc = $signed(c);
            if (!en || mode == RSV) begin
                m_pc = (m_pc + 1) & MASK;
            end else if (mode == RET) begin
                if (m_stack.size() > 0) m_pc = m_stack.pop_back();
                else begin
                    m_unf = 1;
                    m_pc  = (m_pc + 1) & MASK;
                end
            end else if (mode == CALL) begin
                if (m_stack.size() < RAS_DEPTH) m_stack.push_back((m_pc + 1) & MASK);
                else m_ovf = 1;
                m_pc = (m_pc + int'(off)) & MASK;
            end else begin
                bit taken;
                case (mode)
                    BLT:     taken = sc < 0;
                    BNE:     taken = sc != 0;
                    BEQ:     taken = sc == 0;
                    BGE:     taken = sc >= 0;
                    default: taken = 1'b1;
                endcase
                m_pc = taken ? ((m_pc + int'(off)) & MASK) : ((m_pc + 1) & MASK);
            end
        end
        e.pc  = m_pc;
        e.cnt = m_stack.size();
        e.ovf = m_ovf;
        e.unf = m_unf;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic nop(string tag);
        drive(0, 0, 0, BLT, 8'h00, 8'h00, tag);
    endtask

    task automatic br(br_mode_t mode, logic [7:0] c, logic [7:0] off, string tag);
        drive(0, 0, 1, mode, c, off, tag);
    endtask

    // Monitor: compare DUT state against the oldest queued expectation after every edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, ".pc"},  int'(bus.pc),            e.pc);
            check({e.tag, ".cnt"}, int'(bus.ras_count),     e.cnt);
            check({e.tag, ".ovf"}, int'(bus.ras_overflow),  e.ovf);
            check({e.tag, ".unf"}, int'(bus.ras_underflow), e.unf);
        end
    end

    initial begin
        reset       = 1'b1;
        bus.halt    = 1'b0;
        bus.br_en   = 1'b0;
        bus.br_mode = BLT;
        bus.cmp     = 8'h00;
        bus.offset  = 8'h00;
        #1;
        check("init.pc",  int'(bus.pc),        0);
        check("init.cnt", int'(bus.ras_count), 0);

        // reset then sequential advance, reset mid-run
        drive(1, 0, 0, BLT, 8'h00, 8'h00, "rst");
        for (int i = 0; i < 5; i++) nop("seq");
        drive(1, 0, 1, JMP, 8'h00, 8'h40, "rst_mid");

        // conditional branches from pc=10
        br(JMP, 8'h00, 8'd10, "to10");
        br(BLT, 8'hFF, 8'hFC, "blt_taken");
        br(JMP, 8'h00, 8'd4, "to10b");
        br(BLT, 8'h00, 8'hFC, "blt_not");
        br(JMP, 8'h00, 8'hFF, "to10c");
        br(BGE, 8'h00, 8'd3, "bge_zero");
        br(BNE, 8'h00, 8'd7, "bne_not");
        br(BEQ, 8'h00, 8'd7, "beq_taken");
        br(RSV, 8'h00, 8'd50, "rsv");

        // wrap-around
        drive(1, 0, 0, BLT, 8'h00, 8'h00, "rst2");
        br(JMP, 8'h00, 8'hFE, "toFE");
        br(JMP, 8'h00, 8'd5, "wrap_jmp");
        br(JMP, 8'h00, 8'hFC, "toFF");
        nop("wrap_seq");

        // call / return and nesting
        br(JMP, 8'h00, 8'd20, "to20");
        br(CALL, 8'h00, 8'd10, "call1");
        br(RET, 8'h55, 8'h77, "ret1");
        br(CALL, 8'h00, 8'd5, "ncall1");
        br(CALL, 8'h00, 8'd5, "ncall2");
        br(RET, 8'h00, 8'h00, "nret2");
        br(RET, 8'h00, 8'h00, "nret1");

        // overflow / underflow
        for (int i = 0; i < 5; i++) br(CALL, 8'h00, 8'd16, "ovf_call");
        for (int i = 0; i < 5; i++) br(RET, 8'h00, 8'h00, "unf_ret");

        // halt freeze, then reset over halt
        drive(1, 0, 0, BLT, 8'h00, 8'h00, "rst3");
        br(CALL, 8'h00, 8'd9, "pre_halt");
        for (int i = 0; i < 3; i++) drive(0, 1, 1, CALL, 8'h00, 8'd9, "halt");
        drive(1, 1, 1, CALL, 8'h00, 8'd9, "halt_rst");

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit r, h, en;
            r  = ($urandom_range(0, 99) < 2);
            h  = ($urandom_range(0, 99) < 10);
            en = ($urandom_range(0, 99) < 65);
            drive(r, h, en, br_mode_t'($urandom_range(0, 7)),
                  8'($urandom), 8'($urandom), "rnd");
        end

        // drain the scoreboard with a bounded wait
        begin
            int budget = 20;
            while (sb.size() > 0 && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            if (sb.size() > 0) begin
                tests++;
                failed++;
                $display("FAIL drain: got %0d pending expected 0", sb.size());
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
